// File: rtl/sf_dft_accum_mc_if.sv
// sf_dft_accum_mc_if: sample input, clear and result-FIFO handshake bundle
// for the multi-channel single-bin DFT accumulator.
interface sf_dft_accum_mc_if #(
  parameter int CHANELS = 4,
  parameter int X_WIDTH = 16,
  parameter int S_WIDTH = 40
);
  localparam int CW = $clog2(CHANELS);

  logic                      i_clr;
  logic                      i_vld;
  logic [CW-1:0]             i_ch;
  logic signed [X_WIDTH-1:0] x1;
  logic signed [X_WIDTH-1:0] x2;
  logic                      o_vld;
  logic                      o_rdy;
  logic [CW-1:0]             o_ch;
  logic signed [S_WIDTH-1:0] o_re1;
  logic signed [S_WIDTH-1:0] o_im1;
  logic signed [S_WIDTH-1:0] o_re2;
  logic signed [S_WIDTH-1:0] o_im2;
  logic                      o_ovf;

  // Sample source / result consumer side
  modport master (
    output i_clr, i_vld, i_ch, x1, x2, o_rdy,
    input  o_vld, o_ch, o_re1, o_im1, o_re2, o_im2, o_ovf
  );

  // Accumulator side
  modport slave (
    input  i_clr, i_vld, i_ch, x1, x2, o_rdy,
    output o_vld, o_ch, o_re1, o_im1, o_re2, o_im2, o_ovf
  );
endinterface

// File: rtl/sf_dft_accum_mc.sv
// sf_dft_accum_mc: multi-channel single-bin DFT accumulator.
// Correlates x1/x2 against an elaboration-time cos/sin table, integrates
// FRAME_LENGTH samples per frame, averages 2^MEAN_STEPS frames and queues
// per-channel (re, im) results in a first-word-fall-through FIFO.
// Optional: define SF_DFT_HANN_WINDOW_EN to pre-multiply the table by a Hann window.
module sf_dft_accum_mc #(
  parameter int CHANELS      = 4,
  parameter int X_WIDTH      = 16,
  parameter int W_WIDTH      = 16,
  parameter int S_WIDTH      = 40,
  parameter int FRAME_LENGTH = 22,
  parameter int MEAN_STEPS   = 0,
  parameter int OUT_DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  sf_dft_accum_mc_if.slave bus
);
  localparam int  CW   = $clog2(CHANELS);
  localparam int  KW   = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
  localparam int  FW   = (MEAN_STEPS > 0) ? MEAN_STEPS : 1;
  localparam int  PW   = X_WIDTH + W_WIDTH;
  localparam int  AW   = $clog2(OUT_DEPTH);
  localparam real PI   = 3.14159265358979323846;
  localparam real AMP  = 2.0 ** (W_WIDTH - 1) - 1.0;

  localparam logic [KW-1:0] K_LAST  = KW'(FRAME_LENGTH - 1);
  localparam logic [KW-1:0] K_ONE   = KW'(1);
  localparam logic [FW-1:0] F_LAST  = FW'((1 << MEAN_STEPS) - 1);
  localparam logic [FW-1:0] F_ONE   = FW'(1);
  localparam logic [AW:0]   P_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   P_DEPTH = (AW + 1)'(OUT_DEPTH);

  typedef struct packed {
    logic signed [S_WIDTH-1:0] re1;
    logic signed [S_WIDTH-1:0] im1;
    logic signed [S_WIDTH-1:0] re2;
    logic signed [S_WIDTH-1:0] im2;
  } sum_t;

  typedef struct packed {
    logic [CW-1:0] ch;
    sum_t          s;
  } res_t;

  function automatic logic signed [W_WIDTH-1:0] weight(input int k, input bit is_sin);
    real ph, v;
    ph = 2.0 * PI * $itor(k) / $itor(FRAME_LENGTH);
    v  = AMP * (is_sin ? $sin(ph) : $cos(ph));
`ifdef SF_DFT_HANN_WINDOW_EN
    v  = v * (0.5 - 0.5 * $cos(ph));
`endif
    // round half away from zero
    if (v >= 0.0) return W_WIDTH'($rtoi(v + 0.5));
    else          return W_WIDTH'(-$rtoi(0.5 - v));
  endfunction

  function automatic logic signed [S_WIDTH-1:0] sx(input logic signed [PW-1:0] p);
    return {{(S_WIDTH - PW){p[PW-1]}}, p};
  endfunction

  logic signed [W_WIDTH-1:0] c_tab [FRAME_LENGTH];
  logic signed [W_WIDTH-1:0] s_tab [FRAME_LENGTH];

  for (genvar g = 0; g < FRAME_LENGTH; g++) begin : g_tab
    localparam logic signed [W_WIDTH-1:0] CV = weight(g, 1'b0);
    localparam logic signed [W_WIDTH-1:0] SV = weight(g, 1'b1);
    assign c_tab[g] = CV;
    assign s_tab[g] = SV;
  end

  logic [KW-1:0] k_cnt [CHANELS];
  logic [FW-1:0] f_cnt [CHANELS];
  logic [KW-1:0] cur_k;
  logic [FW-1:0] cur_f;

  logic                      s0_vld, s0_last;
  logic [CW-1:0]             s0_ch;
  logic signed [X_WIDTH-1:0] s0_x1, s0_x2;
  logic signed [W_WIDTH-1:0] s0_c, s0_s;

  logic                      s1_vld, s1_last;
  logic [CW-1:0]             s1_ch;
  logic signed [PW-1:0]      s1_re1, s1_im1, s1_re2, s1_im2;

  sum_t acc [CHANELS];
  sum_t cur_sum, nxt_sum;
  res_t new_res, head;
  res_t mem [OUT_DEPTH];

  logic [AW:0] wr_ptr, rd_ptr, fifo_cnt;
  logic        empty, full, pop, push_req, push, ovf_q;

  assign cur_k = k_cnt[bus.i_ch];
  assign cur_f = f_cnt[bus.i_ch];

  // E0: capture sample and table weights, advance per-channel sample/frame counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld  <= 1'b0;
      s0_last <= 1'b0;
      s0_ch   <= '0;
      s0_x1   <= '0;
      s0_x2   <= '0;
      s0_c    <= '0;
      s0_s    <= '0;
      for (int unsigned i = 0; i < CHANELS; i++) begin
        k_cnt[i] <= '0;
        f_cnt[i] <= '0;
      end
    end else if (bus.i_clr) begin
      s0_vld <= 1'b0;
      for (int unsigned i = 0; i < CHANELS; i++) begin
        k_cnt[i] <= '0;
        f_cnt[i] <= '0;
      end
    end else begin
      s0_vld <= bus.i_vld;
      if (bus.i_vld) begin
        s0_ch   <= bus.i_ch;
        s0_x1   <= bus.x1;
        s0_x2   <= bus.x2;
        s0_c    <= c_tab[cur_k];
        s0_s    <= s_tab[cur_k];
        s0_last <= (cur_k == K_LAST) && (cur_f == F_LAST);
        if (cur_k == K_LAST) begin
          k_cnt[bus.i_ch] <= '0;
          f_cnt[bus.i_ch] <= (cur_f == F_LAST) ? '0 : cur_f + F_ONE;
        end else begin
          k_cnt[bus.i_ch] <= cur_k + K_ONE;
        end
      end
    end
  end

  // E1: the four signed products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_ch   <= '0;
      s1_re1  <= '0;
      s1_im1  <= '0;
      s1_re2  <= '0;
      s1_im2  <= '0;
    end else if (bus.i_clr) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld  <= s0_vld;
      s1_last <= s0_last;
      s1_ch   <= s0_ch;
      s1_re1  <= PW'(s0_x1) * PW'(s0_c);
      s1_im1  <= PW'(s0_x1) * PW'(s0_s);
      s1_re2  <= PW'(s0_x2) * PW'(s0_c);
      s1_im2  <= PW'(s0_x2) * PW'(s0_s);
    end
  end

  // E2 datapath: read-modify-write sums and the averaged result for completion
  always_comb begin
    cur_sum        = acc[s1_ch];
    nxt_sum.re1    = cur_sum.re1 + sx(s1_re1);
    nxt_sum.im1    = cur_sum.im1 - sx(s1_im1);
    nxt_sum.re2    = cur_sum.re2 + sx(s1_re2);
    nxt_sum.im2    = cur_sum.im2 - sx(s1_im2);
    new_res.ch     = s1_ch;
    new_res.s.re1  = nxt_sum.re1 >>> MEAN_STEPS;
    new_res.s.im1  = nxt_sum.im1 >>> MEAN_STEPS;
    new_res.s.re2  = nxt_sum.re2 >>> MEAN_STEPS;
    new_res.s.im2  = nxt_sum.im2 >>> MEAN_STEPS;
  end

  // E2: accumulator update; a completing sample leaves the channel at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANELS; i++) acc[i] <= '0;
    end else if (bus.i_clr) begin
      for (int unsigned i = 0; i < CHANELS; i++) acc[i] <= '0;
    end else if (s1_vld) begin
      acc[s1_ch] <= s1_last ? '0 : nxt_sum;
    end
  end

  assign fifo_cnt = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (fifo_cnt == P_DEPTH);
  assign pop      = !empty && bus.o_rdy;
  assign push_req = s1_vld && s1_last && !bus.i_clr;
  // when full, the slot being written is the head being popped this edge
  assign push     = push_req && (!full || pop);

  // Result FIFO storage, pointers and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= new_res;
        wr_ptr              <= wr_ptr + P_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + P_ONE;
      if (bus.i_clr)                   ovf_q <= 1'b0;
      else if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign bus.o_vld = !empty;
  assign bus.o_ch  = head.ch;
  assign bus.o_re1 = head.s.re1;
  assign bus.o_im1 = head.s.im1;
  assign bus.o_re2 = head.s.re2;
  assign bus.o_im2 = head.s.im2;
  assign bus.o_ovf = ovf_q;
endmodule

// File: tb/tb_sf_dft_accum_mc.sv
// tb_sf_dft_accum_mc: directed scenarios plus randomized traffic for
// sf_dft_accum_mc, checked against a per-channel arithmetic reference model.
// dut0 runs MEAN_STEPS=0, dut1 runs MEAN_STEPS=1 (FRAME_LENGTH=4, OUT_DEPTH=2).
module tb_sf_dft_accum_mc;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sf_dft_accum_mc_if #(.CHANELS(4), .X_WIDTH(16), .S_WIDTH(40)) b0 ();
  sf_dft_accum_mc_if #(.CHANELS(4), .X_WIDTH(16), .S_WIDTH(40)) b1 ();

  sf_dft_accum_mc #(.CHANELS(4), .X_WIDTH(16), .W_WIDTH(16), .S_WIDTH(40),
                    .FRAME_LENGTH(FL), .MEAN_STEPS(0), .OUT_DEPTH(2))
    dut0 (.clk(clk), .rst(rst), .bus(b0));

  sf_dft_accum_mc #(.CHANELS(4), .X_WIDTH(16), .W_WIDTH(16), .S_WIDTH(40),
                    .FRAME_LENGTH(FL), .MEAN_STEPS(1), .OUT_DEPTH(2))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    int     ch;
    longint re1, im1, re2, im2;
  } res_t;

  longint m_acc [2][4][4];   // [dut][channel][re1, im1, re2, im2]
  int     m_n   [2][4];      // samples seen per channel since last clear
  res_t   q0[$];
  res_t   q1[$];
  int     n_checks = 0;
  int     n_err    = 0;
  int     pop_cnt  = 0;

  function automatic longint wt(input int k, input bit is_sin);
    real ph, v;
    ph = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(FL);
    v  = 32767.0 * (is_sin ? $sin(ph) : $cos(ph));
`ifdef SF_DFT_HANN_WINDOW_EN
    v  = v * (0.5 - 0.5 * $cos(ph));
`endif
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    else          return -longint'($rtoi(0.5 - v));
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // dut index doubles as its MEAN_STEPS value
  task automatic m_feed(input int d, input int ch, input int x1, input int x2);
    int   k;
    res_t r;
    k = m_n[d][ch] % FL;
    m_acc[d][ch][0] += longint'(x1) * wt(k, 1'b0);
    m_acc[d][ch][1] -= longint'(x1) * wt(k, 1'b1);
    m_acc[d][ch][2] += longint'(x2) * wt(k, 1'b0);
    m_acc[d][ch][3] -= longint'(x2) * wt(k, 1'b1);
    m_n[d][ch]++;
    if (m_n[d][ch] % (FL * (1 << d)) == 0) begin
      r.ch  = ch;
      r.re1 = m_acc[d][ch][0] >>> d;
      r.im1 = m_acc[d][ch][1] >>> d;
      r.re2 = m_acc[d][ch][2] >>> d;
      r.im2 = m_acc[d][ch][3] >>> d;
      if (d == 0) q0.push_back(r); else q1.push_back(r);
      for (int f = 0; f < 4; f++) m_acc[d][ch][f] = 0;
    end
  endtask

  task automatic m_clear(input int d);
    for (int c = 0; c < 4; c++) begin
      m_n[d][c] = 0;
      for (int f = 0; f < 4; f++) m_acc[d][c][f] = 0;
    end
  endtask

  task automatic check_pop();
    res_t r;
    n_checks++;
    pop_cnt++;
    assert (q0.size() != 0) else begin
      n_err++;
      $error("FAIL pop_unexpected observed ch=%0d re1=%0d expected no result", b0.o_ch, b0.o_re1);
    end
    if (q0.size() != 0) begin
      r = q0.pop_front();
      chk("pop_ch",  b0.o_ch,  r.ch);
      chk("pop_re1", b0.o_re1, r.re1);
      chk("pop_im1", b0.o_im1, r.im1);
      chk("pop_re2", b0.o_re2, r.re2);
      chk("pop_im2", b0.o_im2, r.im2);
    end
  endtask

  // one clock; dut0 pops are scored against the model as they happen
  task automatic tick();
    if (b0.o_vld === 1'b1 && b0.o_rdy === 1'b1) check_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input int ch, input int x1, input int x2);
    if (d == 0) begin
      b0.i_vld = 1'b1; b0.i_ch = 2'(ch); b0.x1 = 16'(x1); b0.x2 = 16'(x2);
    end else begin
      b1.i_vld = 1'b1; b1.i_ch = 2'(ch); b1.x1 = 16'(x1); b1.x2 = 16'(x2);
    end
    m_feed(d, ch, x1, x2);
    tick();
    b0.i_vld = 1'b0;
    b1.i_vld = 1'b0;
  endtask

  task automatic frame_a(input int d, input int ch);
    send(d, ch, 100, 5); send(d, ch, 0, 5); send(d, ch, -100, 5); send(d, ch, 0, 5);
  endtask

  initial begin
    res_t r;
    int   xs [4];
    xs = '{0, 100, 0, -100};
    b0.i_clr = 1'b0; b0.i_vld = 1'b0; b0.i_ch = '0; b0.x1 = '0; b0.x2 = '0; b0.o_rdy = 1'b1;
    b1.i_clr = 1'b0; b1.i_vld = 1'b0; b1.i_ch = '0; b1.x1 = '0; b1.x2 = '0; b1.o_rdy = 1'b1;
    m_clear(0);
    m_clear(1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_vld", b0.o_vld, 0);
    chk("rst_o_ovf", b0.o_ovf, 0);
    chk("rst_o_re1", b0.o_re1, 0);
    chk("rst_o_ch",  b0.o_ch,  0);
    chk("rst_b1_o_vld", b1.o_vld, 0);
    rst = 1'b0;
    tick();

    // single ch0 frame, latency of 3 edges from the last accepted sample
    frame_a(0, 0);
    chk("s1_lat1", b0.o_vld, 0);
    tick();
    chk("s1_lat2", b0.o_vld, 0);
    tick();
    chk("s1_lat3", b0.o_vld, 1);
`ifndef SF_DFT_HANN_WINDOW_EN
    chk("s1_re1", b0.o_re1, 6553400);
    chk("s1_im1", b0.o_im1, 0);
    chk("s1_re2", b0.o_re2, 0);
`endif
    tick();

    // ch1/ch2 interleaved sample by sample
    for (int i = 0; i < 4; i++) begin
      send(0, 1, xs[i], 0);
      send(0, 2, xs[i], 0);
    end
    tick();
    chk("s2_first_vld", b0.o_vld, 1);
    chk("s2_first_ch",  b0.o_ch,  1);
`ifndef SF_DFT_HANN_WINDOW_EN
    chk("s2_first_im1", b0.o_im1, -6553400);
`endif
    tick();
    chk("s2_second_vld", b0.o_vld, 1);
    chk("s2_second_ch",  b0.o_ch,  2);
    tick();

    // two-frame average on dut1, nothing after the first frame
    frame_a(1, 3);
    for (int i = 0; i < 4; i++) begin
      chk("s3_no_early", b1.o_vld, 0);
      tick();
    end
    frame_a(1, 3);
    tick();
    tick();
    chk("s3_vld", b1.o_vld, 1);
    chk("s3_qsize", q1.size(), 1);
    if (q1.size() != 0) begin
      r = q1.pop_front();
      chk("s3_ch",  b1.o_ch,  r.ch);
      chk("s3_re1", b1.o_re1, r.re1);
      chk("s3_im1", b1.o_im1, r.im1);
      chk("s3_re2", b1.o_re2, r.re2);
    end
`ifndef SF_DFT_HANN_WINDOW_EN
    chk("s3_re1_lit", b1.o_re1, 6553400);
`endif
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("s3_single", b1.o_vld, 0);
      tick();
    end

    // overflow: three frames into a two-deep FIFO with the consumer stalled
    b0.o_rdy = 1'b0;
    for (int i = 0; i < 3; i++) frame_a(0, 0);
    repeat (3) tick();
    chk("s4_ovf", b0.o_ovf, 1);
    chk("s4_vld", b0.o_vld, 1);
    void'(q0.pop_back());
    pop_cnt  = 0;
    b0.o_rdy = 1'b1;
    repeat (5) tick();
    chk("s4_pops", pop_cnt, 2);
    chk("s4_ovf_sticky", b0.o_ovf, 1);

    // async reset in the middle of a frame
    send(0, 0, rnd16(), rnd16());
    send(0, 0, rnd16(), rnd16());
    rst = 1'b1;
    #1;
    chk("s5_rst_vld", b0.o_vld, 0);
    chk("s5_rst_ovf", b0.o_ovf, 0);
    chk("s5_rst_re1", b0.o_re1, 0);
    m_clear(0);
    m_clear(1);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    frame_a(0, 0);
    tick();
    tick();
    chk("s5_vld", b0.o_vld, 1);
`ifndef SF_DFT_HANN_WINDOW_EN
    chk("s5_re1", b0.o_re1, 6553400);
`endif
    tick();

    // clear mid-frame; earlier FIFO entry survives
    b0.o_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1, rnd16(), rnd16());
    repeat (3) tick();
    chk("s6_pre_vld", b0.o_vld, 1);
    send(0, 0, 100, 5);
    send(0, 0, 0, 5);
    b0.i_clr = 1'b1; b0.i_vld = 1'b1; b0.i_ch = 2'd0; b0.x1 = 16'sd77; b0.x2 = 16'sd9;
    tick();
    b0.i_clr = 1'b0; b0.i_vld = 1'b0;
    m_clear(0);
    frame_a(0, 0);
    repeat (3) tick();
    chk("s6_ovf", b0.o_ovf, 0);
    chk("s6_head_ch", b0.o_ch, 1);
    pop_cnt  = 0;
    b0.o_rdy = 1'b1;
    repeat (4) tick();
    chk("s6_pops", pop_cnt, 2);

    // randomized traffic, consumer always ready
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      else send(0, int'($urandom_range(0, 3)), rnd16(), rnd16());
    end
    repeat (6) tick();
    chk("rand_drained", q0.size(), 0);
    chk("rand_no_ovf", b0.o_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/sf_dft_accum_mc.md
Name: sf_dft_accum_mc

Overview:
Multi-channel single-bin DFT accumulator for the sf_fft chain. It correlates two sample streams, x1 and x2, against an elaboration-time cos/sin table. Each channel integrates FRAME_LENGTH samples per frame and averages over 2^MEAN_STEPS frames. Completed per-channel (re, im) pairs go into an output FIFO with a valid/ready handshake, ready for the downstream CORDIC phase/magnitude stage.

Parameters:
CHANELS, 4, number of independent channels (power of two, >=2)
X_WIDTH, 16, signed input sample width
W_WIDTH, 16, signed weight width; table scale is 2^(W_WIDTH-1)-1
S_WIDTH, 40, accumulator/output width; must be >= X_WIDTH+W_WIDTH+$clog2(FRAME_LENGTH)+MEAN_STEPS
FRAME_LENGTH, 22, samples per frame (>=2)
MEAN_STEPS, 0, log2 of frames averaged per result
OUT_DEPTH, 4, output FIFO depth (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_clr  in  1  synchronous clear of all channels
i_vld  in  1  input sample strobe
i_ch  in  $clog2(CHANELS)  channel of the current sample
x1  in  X_WIDTH  signed sample, stream 1
x2  in  X_WIDTH  signed sample, stream 2
o_vld  out  1  FIFO head valid
o_rdy  in  1  downstream ready
o_ch  out  $clog2(CHANELS)  channel of the head result
o_re1, o_im1, o_re2, o_im2  out  S_WIDTH each  signed averaged DFT bin
o_ovf  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (rst=1, async): every output is 0. Also zeroes all accumulators, sample counters k[ch], frame counters f[ch], pipeline valids and FIFO pointers.
- Weights:
  - C[k] = round(A*cos(2*pi*k/FRAME_LENGTH)), S[k] = round(A*sin(2*pi*k/FRAME_LENGTH)), where A = 2^(W_WIDTH-1)-1.
  - Round half away from zero. Table is built at elaboration.
- Pipeline, 3 stages:
  - E0 (edge with i_vld=1): register x1, x2, i_ch, C[k[i_ch]], S[k[i_ch]]. Advance k[i_ch]; on wrap FRAME_LENGTH-1 -> 0, advance f[i_ch] modulo 2^MEAN_STEPS.
  - E1: four signed products of width X_WIDTH+W_WIDTH.
  - E2: re += x*C and im -= x*S, sign-extended to S_WIDTH, wrapping modulo 2^S_WIDTH.
- Back-to-back samples on the same channel accumulate correctly with no stall. Stage E2 is the sole read-modify-write point.
- Result completion:
  - Triggered when the E2 sample is the last of frame 2^MEAN_STEPS (k=FRAME_LENGTH-1 and f=2^MEAN_STEPS-1).
  - Each final sum is arithmetically shifted right by MEAN_STEPS and written to the FIFO.
  - The channel accumulators reset to 0 in the same edge.
- Latency: o_vld is high in the cycle after E2 when the FIFO was empty, i.e. 3 edges from acceptance of the last sample.
- FIFO:
  - First-word-fall-through; a pop occurs on o_vld&o_rdy.
  - Push and pop in the same cycle while full is allowed and does not drop the result.
- Full FIFO with a completing result and no pop: the result is discarded, o_ovf is set, and the accumulator still clears. o_ovf is cleared only by rst or i_clr.
- i_clr=1:
  - Zeroes accumulators, counters, pipeline valids and o_ovf.
  - Any i_vld in the same cycle is dropped.
  - FIFO contents are kept and the output handshake continues.
- Out-of-range i_ch cannot occur (CHANELS is a power of two).

Optional Feature:
SF_DFT_HANN_WINDOW_EN
- Defined: table entries are pre-multiplied by the Hann window w[k] = 0.5-0.5*cos(2*pi*k/FRAME_LENGTH), rounded once at elaboration. No latency or port change.
- Undefined: rectangular window, weights exactly as above.

Test Plan:
Common configuration for all scenarios: FRAME_LENGTH=4, MEAN_STEPS=0, W_WIDTH=16, OUT_DEPTH=2.
1. ch0, x1 = 100,0,-100,0 and x2 = 5,5,5,5 -> one result with o_ch=0, o_re1=6553400, o_im1=0, o_re2=0, o_im2=0. o_vld rises 3 edges after the 4th sample.
2. Interleave ch1/ch2 sample by sample, each with x1 = 0,100,0,-100 -> ch1 result first, o_re1=0, o_im1=-6553400; ch2 result identical, the following cycle.
3. MEAN_STEPS=1, ch3 fed two frames of x1 = 100,0,-100,0 -> exactly one result, o_re1=6553400. Nothing is output after the first frame.
4. o_rdy=0 and 3 completed ch0 frames -> FIFO holds 2 results, o_ovf=1. Raise o_rdy -> exactly 2 pops.
5. Assert rst after 2 samples of a ch0 frame, then send a full frame -> outputs 0 during reset; the result matches scenario 1 with no residue.
6. i_clr together with i_vld on the 3rd sample, then 4 fresh samples -> the result reflects only the fresh 4 samples; FIFO entries present before the clear are still popped.
